oled_text_buffer: RTL and testbench

// Upstream feeder for the OLED string writer: owns the 64-char (4x16) display image and drives its 512-bit string input.

---
 rtl/oled_text_buffer.sv | 112 +++++++++++
 tb/tb_oled_text_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/oled_text_buffer.sv
// oled_text_buffer: 4x16 OLED text image with a fixed prompt region and an editable entry region.
// Ports: clock/reset (sync, active-high); prompt_in (prompt text, char p at MSB-first byte p);
//   char_in/char_valid/char_ready (ASCII entry handshake); backspace, clear (one-cycle strobes);
//   display_string (512-bit image, position 0 in the top byte); entry_value (unmasked entry, slot 0 in the top byte);
//   entry_len, entry_full, busy (fill in progress), update (one-cycle pulse when the image changes).
// Build option: define MASK_INPUT_EN to show MASK_CHAR on the display in place of each entered char.
module oled_text_buffer #(
    parameter int EDIT_START = 32,
    parameter int EDIT_LEN = 16,
    parameter logic [7:0] PAD_CHAR = 8'h20,
    parameter logic [7:0] MASK_CHAR = 8'h2A
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [8*EDIT_START-1:0]        prompt_in,
    input  logic [7:0]                     char_in,
    input  logic                           char_valid,
    output logic                           char_ready,
    input  logic                           backspace,
    input  logic                           clear,
    output logic [511:0]                   display_string,
    output logic [8*EDIT_LEN-1:0]          entry_value,
    output logic [$clog2(EDIT_LEN+1)-1:0]  entry_len,
    output logic                           entry_full,
    output logic                           busy,
    output logic                           update
);
    localparam int LW = $clog2(EDIT_LEN+1);
    typedef enum logic {FILL, IDLE} state_t;
    state_t state, state_n;
    logic [5:0] idx, idx_n, d_pos;
    logic [7:0] d_ch, e_ch, prompt_ch;
    logic d_we, e_we, e_clr, upd_n;
    logic [LW-1:0] len_n, e_slot;
    assign busy = state == FILL;
    assign entry_full = entry_len == LW'(EDIT_LEN);
    assign char_ready = state == IDLE && !entry_full;
    always_comb begin
        prompt_ch = PAD_CHAR;
        for (int i = 0; i < EDIT_START; i++)
            if (idx == 6'(i)) prompt_ch = prompt_in[8*(EDIT_START-1-i) +: 8];
    end
    always_comb begin
        state_n = state;
        idx_n = idx;
        len_n = entry_len;
        upd_n = 1'b0;
        d_we = 1'b0;
        d_pos = idx;
        d_ch = PAD_CHAR;
        e_we = 1'b0;
        e_clr = 1'b0;
        e_slot = entry_len;
        e_ch = PAD_CHAR;
        if (state == FILL) begin
            d_we = 1'b1;
            d_ch = {1'b0, idx} < 7'(EDIT_START) ? prompt_ch : PAD_CHAR;
            idx_n = idx + 6'd1;
            if (idx == 6'd63) begin
                state_n = IDLE;
                len_n = '0;
                e_clr = 1'b1;
                upd_n = 1'b1;
            end
        end else if (clear) begin
            state_n = FILL;
            idx_n = '0;
        end else if (backspace) begin
            if (entry_len != '0) begin
                d_we = 1'b1;
                d_pos = 6'(EDIT_START) + 6'(entry_len) - 6'd1;
                e_we = 1'b1;
                e_slot = entry_len - LW'(1);
                len_n = entry_len - LW'(1);
                upd_n = 1'b1;
            end
        end else if (char_valid && char_ready && char_in >= 8'h20 && char_in <= 8'h7E) begin
            d_we = 1'b1;
            d_pos = 6'(EDIT_START) + 6'(entry_len);
`ifdef MASK_INPUT_EN
            d_ch = MASK_CHAR;
`else
            d_ch = char_in;
`endif
            e_we = 1'b1;
            e_ch = char_in;
            len_n = entry_len + LW'(1);
            upd_n = 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
            idx <= '0;
            entry_len <= '0;
            update <= 1'b0;
            display_string <= {64{PAD_CHAR}};
            entry_value <= {EDIT_LEN{PAD_CHAR}};
        end else begin
            state <= state_n;
            idx <= idx_n;
            entry_len <= len_n;
            update <= upd_n;
            for (int p = 0; p < 64; p++)
                if (d_we && d_pos == 6'(p)) display_string[8*(63-p) +: 8] <= d_ch;
            if (e_clr) entry_value <= {EDIT_LEN{PAD_CHAR}};
            else
                for (int i = 0; i < EDIT_LEN; i++)
                    if (e_we && e_slot == LW'(i)) entry_value[8*(EDIT_LEN-1-i) +: 8] <= e_ch;
        end
    end
endmodule

// File: tb/tb_oled_text_buffer.sv
// tb_oled_text_buffer: directed, table-driven bench for oled_text_buffer (default parameters).
// Ports: none; drives every DUT port and prints one summary line.
// Honours MASK_INPUT_EN when choosing the expected display characters.
module tb_oled_text_buffer;
    localparam logic [255:0] P1 = {"ENTER PASSWORD:", {17{8'h20}}};
    localparam logic [255:0] P2 = {"HELLO", {27{8'h20}}};
    logic clock = 1'b0, reset, char_valid, char_ready, backspace, clear;
    logic entry_full, busy, update;
    logic [255:0] prompt_in;
    logic [7:0] char_in;
    logic [511:0] display_string;
    logic [127:0] entry_value;
    logic [4:0] entry_len;
    int total = 0, bad = 0;
    always #5 clock = ~clock;
    oled_text_buffer dut (
        .clock(clock), .reset(reset), .prompt_in(prompt_in), .char_in(char_in),
        .char_valid(char_valid), .char_ready(char_ready), .backspace(backspace),
        .clear(clear), .display_string(display_string), .entry_value(entry_value),
        .entry_len(entry_len), .entry_full(entry_full), .busy(busy), .update(update)
    );
    typedef struct {
        logic clr, bs, vld;
        logic [7:0] ch;
        logic rdy;
        int len;
        logic upd;
        int pos;
        logic [7:0] pch;
        logic ent;
        logic [31:0] ev;
    } vec_t;
    vec_t tv[15];
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [7:0] dpos(input int p);
        return display_string[511-8*p -: 8];
    endfunction
    function automatic logic [7:0] show(input logic [7:0] c, input logic ent);
`ifdef MASK_INPUT_EN
        return ent ? 8'h2A : c;
`else
        return c;
`endif
    endfunction
    task automatic step(input logic c, input logic b, input logic v, input logic [7:0] ch,
                        input logic rdy, input int len, input logic upd, input string nm);
        clear = c;
        backspace = b;
        char_valid = v;
        char_in = ch;
        chk({nm, "_ready"}, char_ready, rdy);
        @(posedge clock);
        #1;
        clear = 0;
        backspace = 0;
        char_valid = 0;
        chk({nm, "_len"}, entry_len, len);
        chk({nm, "_update"}, update, upd);
    endtask
    task automatic wait_fill(input string nm, input logic [255:0] pr);
        int cyc = 0, ups = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
            ups += int'(update);
        end while (busy && cyc < 200);
        chk({nm, "_cycles"}, cyc, 64);
        chk({nm, "_updates"}, ups, 1);
        chk({nm, "_update_last"}, update, 1);
        chk({nm, "_len"}, entry_len, 0);
        chk({nm, "_prompt"}, display_string[511:256], pr);
        chk({nm, "_entry_region"}, display_string[255:0], {32{8'h20}});
        chk({nm, "_entry_value"}, entry_value, {16{8'h20}});
    endtask
    initial begin
        int hs;
        tv[0]  = '{0, 0, 0, 8'h00, 1, 0, 0, 32, 8'h20, 0, 32'h20202020};
        tv[1]  = '{0, 1, 0, 8'h00, 1, 0, 0, 32, 8'h20, 0, 32'h20202020};
        tv[2]  = '{0, 0, 1, 8'h31, 1, 1, 1, 32, 8'h31, 1, 32'h31202020};
        tv[3]  = '{0, 0, 1, 8'h32, 1, 2, 1, 33, 8'h32, 1, 32'h31322020};
        tv[4]  = '{0, 0, 1, 8'h33, 1, 3, 1, 34, 8'h33, 1, 32'h31323320};
        tv[5]  = '{0, 0, 1, 8'h34, 1, 4, 1, 35, 8'h34, 1, 32'h31323334};
        tv[6]  = '{0, 0, 0, 8'h00, 1, 4, 0, 35, 8'h34, 1, 32'h31323334};
        tv[7]  = '{0, 1, 0, 8'h00, 1, 3, 1, 35, 8'h20, 0, 32'h31323320};
        tv[8]  = '{0, 0, 1, 8'h0D, 1, 3, 0, 34, 8'h33, 1, 32'h31323320};
        tv[9]  = '{0, 0, 1, 8'h7F, 1, 3, 0, 35, 8'h20, 0, 32'h31323320};
        tv[10] = '{0, 0, 1, 8'h7E, 1, 4, 1, 35, 8'h7E, 1, 32'h3132337E};
        tv[11] = '{0, 1, 1, 8'h5A, 1, 3, 1, 35, 8'h20, 0, 32'h31323320};
        tv[12] = '{0, 0, 1, 8'h1F, 1, 3, 0, 35, 8'h20, 0, 32'h31323320};
        tv[13] = '{0, 0, 1, 8'h20, 1, 4, 1, 35, 8'h20, 1, 32'h31323320};
        tv[14] = '{0, 1, 0, 8'h00, 1, 3, 1, 35, 8'h20, 0, 32'h31323320};
        prompt_in = P1;
        clear = 0;
        backspace = 0;
        char_valid = 0;
        char_in = 0;
        reset = 1;
        @(posedge clock);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_ready", char_ready, 0);
        chk("rst_len", entry_len, 0);
        chk("rst_update", update, 0);
        chk("rst_display", display_string, {64{8'h20}});
        chk("rst_entry", entry_value, {16{8'h20}});
        reset = 0;
        wait_fill("fill0", P1);
        for (int i = 0; i < 15; i++) begin
            step(tv[i].clr, tv[i].bs, tv[i].vld, tv[i].ch, tv[i].rdy, tv[i].len, tv[i].upd, $sformatf("v%0d", i));
            chk($sformatf("v%0d_pos", i), dpos(tv[i].pos), show(tv[i].pch, tv[i].ent));
            chk($sformatf("v%0d_ev", i), entry_value[127:96], tv[i].ev);
        end
        chk("seq_pos32", dpos(32), show(8'h31, 1));
        hs = 0;
        char_in = 8'h41;
        char_valid = 1;
        for (int i = 0; i < 20; i++) begin
            hs += int'(char_ready);
            @(posedge clock);
            #1;
        end
        chk("full_handshakes", hs, 13);
        chk("full_len", entry_len, 16);
        chk("full_flag", entry_full, 1);
        chk("full_ready", char_ready, 0);
        chk("full_update", update, 0);
        chk("full_ev_hi", entry_value[127:96], 32'h31323341);
        chk("full_ev_last", entry_value[7:0], 8'h41);
        chk("full_pos47", dpos(47), show(8'h41, 1));
        chk("full_pos48", dpos(48), 8'h20);
        char_valid = 0;
        for (int i = 0; i < 13; i++) step(0, 1, 0, 8'h00, i > 0, 15 - i, 1, $sformatf("bs%0d", i));
        chk("bs_pos35", dpos(35), 8'h20);
        step(1, 0, 1, 8'h42, 1, 3, 0, "clr");
        chk("clr_busy", busy, 1);
        chk("clr_ready", char_ready, 0);
        wait_fill("fill_clr", P1);
        prompt_in = P2;
        clear = 1;
        @(posedge clock);
        #1;
        clear = 0;
        repeat (20) @(posedge clock);
        #1;
        chk("mid_busy", busy, 1);
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        chk("mid_rst_busy", busy, 1);
        wait_fill("fill_rst", P2);
        step(0, 0, 1, 8'h0D, 1, 0, 0, "cr");
        step(0, 0, 1, 8'h51, 1, 1, 1, "q");
        chk("q_pos32", dpos(32), show(8'h51, 1));
        chk("q_ev", entry_value[127:120], 8'h51);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
